// File: rtl/rawdns_win_pkg.sv
// Shared constants, FSM state type and window bit-offset helper for the RAWDNS window shifter.
// Combinational definitions only; no latency, no backpressure.
package rawdns_win_pkg;

    localparam int DFLT_BLOCK_RADIUS = 2;
    localparam int DFLT_WIN_RADIUS   = 6;
    localparam int R                 = DFLT_BLOCK_RADIUS + DFLT_WIN_RADIUS;
    localparam int TOTAL_LENGTH      = 2 * R + 1;
    localparam int REF_LENGTH        = 2 * DFLT_BLOCK_RADIUS + 1;

    typedef enum logic [2:0] {
        WAIT_FRAME,
        WAIT_LINE,
        FILL,
        RUN,
        LINE_END
    } state_e;

    // Column-major packing: column c holds len pixels, row r within it.
    function automatic int win_bit_offset(input int c, input int r, input int len, input int dw);
        return (c * len + r) * dw;
    endfunction

endpackage

// File: rtl/rawdns_window_shift_if.sv
// Column-in / window-out bus of the RAWDNS window shifter.
// Pure wiring; the column side has no ready signal, the sink must always accept windows.
interface rawdns_window_shift_if #(
    parameter int DATA_WIDTH   = 12,
    parameter int CNT_WIDTH    = 10,
    parameter int TOTAL_LENGTH = rawdns_win_pkg::TOTAL_LENGTH,
    parameter int REF_LENGTH   = rawdns_win_pkg::REF_LENGTH
);

    logic                                              frame_sync_i;
    logic                                              line_sync_i;
    logic                                              col_valid_i;
    logic [TOTAL_LENGTH*DATA_WIDTH-1:0]                col_i;
    logic [TOTAL_LENGTH*TOTAL_LENGTH*DATA_WIDTH-1:0]   win_o;
    logic [REF_LENGTH*REF_LENGTH*DATA_WIDTH-1:0]       ref_o;
    logic                                              win_valid_o;
    logic [CNT_WIDTH-1:0]                              center_x_o;
    logic [CNT_WIDTH-1:0]                              center_y_o;
    logic                                              line_done_o;
    logic                                              overrun_o;

    modport master (
        output frame_sync_i, line_sync_i, col_valid_i, col_i,
        input  win_o, ref_o, win_valid_o, center_x_o, center_y_o, line_done_o, overrun_o
    );

    modport slave (
        input  frame_sync_i, line_sync_i, col_valid_i, col_i,
        output win_o, ref_o, win_valid_o, center_x_o, center_y_o, line_done_o, overrun_o
    );

endinterface

// File: rtl/rawdns_col_shreg.sv
// DEPTH-deep column shift register; newest column enters at the top index, oldest sits at index 0.
// Latency 1 cycle from shift_en_i to win_o; holds contents when not enabled, no backpressure.
module rawdns_col_shreg #(
    parameter int DEPTH     = 17,
    parameter int COL_WIDTH = 204
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          shift_en_i,
    input  logic [COL_WIDTH-1:0]          col_i,
    output logic [DEPTH*COL_WIDTH-1:0]    win_o
);

    logic [DEPTH*COL_WIDTH-1:0] win_q;
    logic [DEPTH*COL_WIDTH-1:0] win_d;

    always_comb begin
        win_d = win_q;
        if (shift_en_i) begin
            win_d = {col_i, win_q[DEPTH*COL_WIDTH-1:COL_WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/rawdns_window_shift.sv
// Assembles a registered 17x17 window from incoming columns, tags it with its centre and exposes the 5x5 centre patch.
// Latency 1 cycle from accepted column to window/valid; no backpressure, columns outside a line are dropped.
module rawdns_window_shift
    import rawdns_win_pkg::*;
#(
    parameter int BLOCK_RADIUS = 2,
    parameter int WIN_RADIUS   = 6,
    parameter int DATA_WIDTH   = 12,
    parameter int IMAGE_WIDTH  = 432,
    parameter int IMAGE_HEIGHT = 264,
    parameter int CNT_WIDTH    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rawdns_window_shift_if.slave  bus
);

    localparam int RAD     = BLOCK_RADIUS + WIN_RADIUS;
    localparam int WIN_LEN = 2 * RAD + 1;
    localparam int REF_LEN = 2 * BLOCK_RADIUS + 1;
    localparam int COL_W   = WIN_LEN * DATA_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_COL      = CNT_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] FIRST_WIN_COL = CNT_WIDTH'(WIN_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CTR_OFS       = CNT_WIDTH'(RAD);
    localparam logic [CNT_WIDTH-1:0] LINE_LIMIT    = CNT_WIDTH'(IMAGE_HEIGHT);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   col_cnt_q, col_cnt_d;
    logic [CNT_WIDTH-1:0]   line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0]   center_x_q, center_x_d;
    logic [CNT_WIDTH-1:0]   center_y_q, center_y_d;
    logic                   first_line_q, first_line_d;
    logic                   overrun_q, overrun_d;
    logic                   win_valid_q, win_valid_d;
    logic                   line_done_q, line_done_d;

    logic                   shift_en;
    logic [CNT_WIDTH-1:0]   col_idx;
    logic [CNT_WIDTH-1:0]   line_inc;
    logic [WIN_LEN*COL_W-1:0]                 win;
    logic [REF_LEN*REF_LEN*DATA_WIDTH-1:0]    ref_vec;

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        line_cnt_d   = line_cnt_q;
        first_line_d = first_line_q;
        overrun_d    = overrun_q;
        center_x_d   = center_x_q;
        center_y_d   = center_y_q;
        win_valid_d  = 1'b0;
        line_done_d  = 1'b0;
        shift_en     = 1'b0;
        col_idx      = col_cnt_q;
        line_inc     = line_cnt_q + CNT_ONE;

        if (bus.frame_sync_i) begin
            col_cnt_d    = '0;
            first_line_d = 1'b1;
            overrun_d    = 1'b0;
            state_d      = WAIT_LINE;
        end else if (state_q != WAIT_FRAME && bus.line_sync_i) begin
            col_cnt_d    = '0;
            first_line_d = 1'b0;
            col_idx      = '0;
            if (first_line_q) begin
                line_cnt_d = '0;
                state_d    = FILL;
                shift_en   = bus.col_valid_i;
            end else if (line_inc == LINE_LIMIT) begin
                overrun_d  = 1'b1;
                state_d    = WAIT_FRAME;
            end else begin
                line_cnt_d = line_inc;
                state_d    = FILL;
                shift_en   = bus.col_valid_i;
            end
        end else if (bus.col_valid_i) begin
            if (state_q == FILL || state_q == RUN) begin
                shift_en = 1'b1;
            end else if (state_q == LINE_END) begin
                overrun_d = 1'b1;
            end
        end

        // Column 16 of a line is the first one that completes a full window.
        if (shift_en) begin
            col_cnt_d = col_idx + CNT_ONE;
            if (col_idx >= FIRST_WIN_COL) begin
                win_valid_d = 1'b1;
                center_x_d  = col_idx - CTR_OFS;
                center_y_d  = line_cnt_d;
            end
            if (col_idx == LAST_COL) begin
                line_done_d = 1'b1;
                state_d     = LINE_END;
            end else if (col_idx >= FIRST_WIN_COL) begin
                state_d     = RUN;
            end else begin
                state_d     = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_FRAME;
            col_cnt_q    <= '0;
            line_cnt_q   <= '0;
            first_line_q <= 1'b1;
            overrun_q    <= 1'b0;
            center_x_q   <= '0;
            center_y_q   <= '0;
            win_valid_q  <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            line_cnt_q   <= line_cnt_d;
            first_line_q <= first_line_d;
            overrun_q    <= overrun_d;
            center_x_q   <= center_x_d;
            center_y_q   <= center_y_d;
            win_valid_q  <= win_valid_d;
            line_done_q  <= line_done_d;
        end
    end

    rawdns_col_shreg #(
        .DEPTH     (WIN_LEN),
        .COL_WIDTH (COL_W)
    ) u_col_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift_en),
        .col_i      (bus.col_i),
        .win_o      (win)
    );

    // Reference patch is the window centre, offset WIN_RADIUS in both axes.
    always_comb begin
        ref_vec = '0;
        for (int c = 0; c < REF_LEN; c++) begin
            for (int r = 0; r < REF_LEN; r++) begin
                ref_vec[win_bit_offset(c, r, REF_LEN, DATA_WIDTH) +: DATA_WIDTH] =
                    win[win_bit_offset(c + WIN_RADIUS, r + WIN_RADIUS, WIN_LEN, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    assign bus.win_o       = win;
    assign bus.ref_o       = ref_vec;
    assign bus.win_valid_o = win_valid_q;
    assign bus.center_x_o  = center_x_q;
    assign bus.center_y_o  = center_y_q;
    assign bus.line_done_o = line_done_q;
    assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_rawdns_window_shift.sv
// Randomised bench for rawdns_window_shift against a behavioural frame/line/column model.
module tb_rawdns_window_shift;

    localparam int DW   = 12;
    localparam int CW   = 10;
    localparam int IW   = 432;
    localparam int IH   = 264;
    localparam int TL   = 17;
    localparam int RL   = 5;
    localparam int COLW = TL * DW;
    localparam int WINW = TL * TL * DW;
    localparam int REFW = RL * RL * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rawdns_window_shift_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TOTAL_LENGTH(TL), .REF_LENGTH(RL)) bus ();

    rawdns_window_shift #(
        .BLOCK_RADIUS (2),
        .WIN_RADIUS   (6),
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: last 17 accepted columns plus frame/line bookkeeping.
    logic [COLW-1:0] mwin [TL];
    bit m_frame, m_active, m_ended, m_ovr, e_wv, e_ld;
    int m_lines, m_col, m_y, e_cx, e_cy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < TL; c++) mwin[c] = '0;
        m_frame = 0; m_active = 0; m_ended = 0; m_ovr = 0; e_wv = 0; e_ld = 0;
        m_lines = 0; m_col = 0; m_y = 0; e_cx = 0; e_cy = 0;
    endtask

    task automatic model_accept(input logic [COLW-1:0] col);
        int k;
        for (int c = 0; c < TL - 1; c++) mwin[c] = mwin[c + 1];
        mwin[TL - 1] = col;
        k = m_col;
        m_col++;
        if (k >= TL - 1) begin
            e_wv = 1;
            e_cx = k - (TL - 1) / 2;
            e_cy = m_y;
        end
        if (k == IW - 1) begin
            e_ld = 1;
            m_active = 0;
            m_ended = 1;
        end
    endtask

    task automatic model_step(input bit fs, input bit ls, input bit cv, input logic [COLW-1:0] col);
        e_wv = 0;
        e_ld = 0;
        if (fs) begin
            m_frame = 1; m_active = 0; m_ended = 0; m_lines = 0; m_col = 0; m_ovr = 0;
        end else if (m_frame) begin
            if (ls) begin
                if (m_lines == IH) begin
                    m_ovr = 1; m_frame = 0; m_active = 0; m_ended = 0;
                end else begin
                    m_y = m_lines;
                    m_lines++;
                    m_active = 1;
                    m_ended = 0;
                    m_col = 0;
                    if (cv) model_accept(col);
                end
            end else if (cv) begin
                if (m_active) model_accept(col);
                else if (m_ended) m_ovr = 1;
            end
        end
    endtask

    function automatic logic [WINW-1:0] exp_win();
        logic [WINW-1:0] v;
        for (int c = 0; c < TL; c++)
            for (int r = 0; r < TL; r++)
                v[(c * TL + r) * DW +: DW] = mwin[c][r * DW +: DW];
        return v;
    endfunction

    function automatic logic [REFW-1:0] exp_ref();
        logic [REFW-1:0] v;
        for (int c = 0; c < RL; c++)
            for (int r = 0; r < RL; r++)
                v[(c * RL + r) * DW +: DW] = mwin[c + 6][(r + 6) * DW +: DW];
        return v;
    endfunction

    task automatic compare_all();
        chk("win_valid", 64'(bus.win_valid_o), 64'(e_wv));
        chk("line_done", 64'(bus.line_done_o), 64'(e_ld));
        chk("overrun",   64'(bus.overrun_o),   64'(m_ovr));
        chk("center_x",  64'(bus.center_x_o),  64'(e_cx));
        chk("center_y",  64'(bus.center_y_o),  64'(e_cy));
        chk("win_o_eq",  64'(bus.win_o == exp_win()), 64'd1);
        chk("ref_o_eq",  64'(bus.ref_o == exp_ref()), 64'd1);
    endtask

    task automatic step(input bit fs, input bit ls, input bit cv, input logic [COLW-1:0] col);
        bus.frame_sync_i = fs;
        bus.line_sync_i  = ls;
        bus.col_valid_i  = cv;
        bus.col_i        = col;
        @(posedge clk);
        #1;
        model_step(fs, ls, cv, col);
        compare_all();
    endtask

    function automatic logic [COLW-1:0] pat_col(input int x);
        logic [COLW-1:0] c;
        for (int r = 0; r < TL; r++) c[r * DW +: DW] = DW'(x * 17 + r);
        return c;
    endfunction

    function automatic logic [COLW-1:0] rand_col();
        logic [COLW-1:0] c;
        for (int r = 0; r < TL; r++) c[r * DW +: DW] = DW'($urandom);
        return c;
    endfunction

    function automatic logic [DW-1:0] win_pix(input int c, input int r);
        return bus.win_o[(c * TL + r) * DW +: DW];
    endfunction

    initial begin
        int n_vld, n_ld, last_cx, acc, acc_first;
        bit first, cv;

        bus.frame_sync_i = 1'b0;
        bus.line_sync_i  = 1'b0;
        bus.col_valid_i  = 1'b0;
        bus.col_i        = '0;
        model_reset();
        #2;
        compare_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Line 0 with the x*17+r pattern.
        step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        n_vld = 0; n_ld = 0; first = 1; last_cx = 0;
        for (int x = 0; x < IW; x++) begin
            step(0, 0, 1, pat_col(x));
            if (bus.line_done_o) n_ld++;
            if (bus.win_valid_o) begin
                n_vld++;
                last_cx = int'(bus.center_x_o);
                if (first) begin
                    chk("first_win_col", 64'(x), 64'd16);
                    chk("first_cx", 64'(bus.center_x_o), 64'd8);
                    chk("first_pix00", 64'(win_pix(0, 0)), 64'd0);
                    chk("first_pix1616", 64'(win_pix(16, 16)), 64'd288);
                    first = 0;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, '0);
            if (bus.line_done_o) n_ld++;
        end
        chk("vld_count", 64'(n_vld), 64'd416);
        chk("ld_count", 64'(n_ld), 64'd1);
        chk("last_cx", 64'(last_cx), 64'd423);
        step(0, 0, 1, rand_col());
        chk("ovr_col433", 64'(bus.overrun_o), 64'd1);

        // Line 1: line_sync with a coincident column, random gaps.
        step(0, 1, 1, rand_col());
        acc = 1; acc_first = 0;
        while (acc < IW) begin
            cv = ($urandom_range(0, 3) != 0);
            step(0, 0, cv, rand_col());
            if (cv) acc++;
            if (bus.win_valid_o && acc_first == 0) acc_first = acc;
        end
        chk("l1_first_win_cols", 64'(acc_first), 64'd17);
        chk("l1_center_y", 64'(bus.center_y_o), 64'd1);

        // Short line of 20 columns, then a refill.
        step(0, 1, 0, '0);
        n_vld = 0; n_ld = 0;
        for (int x = 0; x < 20; x++) begin
            step(0, 0, 1, rand_col());
            if (bus.win_valid_o) n_vld++;
            if (bus.line_done_o) n_ld++;
        end
        chk("short_vld", 64'(n_vld), 64'd4);
        chk("short_last_cx", 64'(bus.center_x_o), 64'd11);
        step(0, 1, 0, '0);
        if (bus.line_done_o) n_ld++;
        chk("short_no_ld", 64'(n_ld), 64'd0);
        n_vld = 0;
        for (int x = 0; x < 16; x++) begin
            step(0, 0, 1, rand_col());
            if (bus.win_valid_o) n_vld++;
        end
        chk("refill_novld", 64'(n_vld), 64'd0);
        step(0, 0, 1, rand_col());
        chk("refill_vld", 64'(bus.win_valid_o), 64'd1);
        chk("refill_cx", 64'(bus.center_x_o), 64'd8);

        // Line overrun.
        step(1, 0, 1, rand_col());
        chk("ovr_clr", 64'(bus.overrun_o), 64'd0);
        for (int i = 0; i < IH + 1; i++) step(0, 1, 0, '0);
        chk("ovr_lines", 64'(bus.overrun_o), 64'd1);
        step(0, 1, 0, '0);
        n_vld = 0;
        for (int x = 0; x < 20; x++) begin
            step(0, 0, 1, rand_col());
            if (bus.win_valid_o) n_vld++;
        end
        chk("wait_frame_ignore", 64'(n_vld), 64'd0);
        step(1, 0, 0, '0);
        chk("ovr_clr2", 64'(bus.overrun_o), 64'd0);

        // Random traffic.
        step(0, 1, 0, '0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 1499) == 0, $urandom_range(0, 599) == 0,
                 $urandom_range(0, 4) != 0, rand_col());
        end

        // Asynchronous reset in the middle of a running line.
        step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        for (int x = 0; x < 30; x++) step(0, 0, 1, rand_col());
        chk("pre_rst_vld", 64'(bus.win_valid_o), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        bus.col_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_vld = 0;
        for (int x = 0; x < 20; x++) begin
            step(0, 0, 1, rand_col());
            if (bus.win_valid_o) n_vld++;
        end
        chk("post_rst_ignore", 64'(n_vld), 64'd0);
        step(1, 0, 0, '0);
        step(0, 1, 1, rand_col());
        for (int x = 0; x < 20; x++) step(0, 0, 1, rand_col());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
